// File: rtl/wb_cmd_pkg.sv
// Shared definitions for the Wishbone command master.
// Contents: bus widths, default address width and timeout, FSM state enum,
// and the packed response payload carried from the bus phase to the response phase.
package wb_cmd_pkg;

  localparam int unsigned WB_DAT_W    = 32;
  localparam int unsigned WB_SEL_W    = 4;
  localparam int unsigned ADR_W_DEF   = 4;
  localparam int unsigned TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [WB_DAT_W-1:0] dat;
    logic                err;
  } rsp_t;

endpackage : wb_cmd_pkg

// File: rtl/wb_cmd_master_if.sv
// Bundle of command, response and Wishbone master signals for wb_cmd_master.
// Modports:
//   master - the wb_cmd_master view (drives cmd_ready, rsp_*, wbm_*_o).
//   slave  - the environment view (command producer, response consumer, Wishbone slave).
interface wb_cmd_master_if
  import wb_cmd_pkg::*;
#(
  parameter int unsigned ADR_W = ADR_W_DEF
) ();

  // command channel
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_we;
  logic [ADR_W-1:0]    cmd_adr;
  logic [WB_DAT_W-1:0] cmd_dat;
  logic [WB_SEL_W-1:0] cmd_sel;

  // response channel
  logic                rsp_valid;
  logic                rsp_ready;
  logic [WB_DAT_W-1:0] rsp_dat;
  logic                rsp_err;

  // Wishbone master side
  logic                wbm_cyc_o;
  logic                wbm_stb_o;
  logic                wbm_we_o;
  logic [WB_SEL_W-1:0] wbm_sel_o;
  logic [ADR_W-1:0]    wbm_adr_o;
  logic [WB_DAT_W-1:0] wbm_dat_o;
  logic [WB_DAT_W-1:0] wbm_dat_i;
  logic                wbm_ack_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
    input  rsp_ready,
    input  wbm_dat_i, wbm_ack_i,
    output cmd_ready,
    output rsp_valid, rsp_dat, rsp_err,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
    output rsp_ready,
    output wbm_dat_i, wbm_ack_i,
    input  cmd_ready,
    input  rsp_valid, rsp_dat, rsp_err,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

endinterface : wb_cmd_master_if

// File: rtl/wb_timeout_ctr.sv
// Bus-phase watchdog for wb_cmd_master.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - restart the count at 0 (asserted when a command is accepted)
//   enable    - advance the count by one (a bus cycle passed without ack)
//   expired   - count has reached TIMEOUT-1; decoded from the count register only
module wb_timeout_ctr #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // A TIMEOUT of 1 still needs one bit of storage.
  localparam int unsigned CTR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CTR_W-1:0] count;

  // Count bus cycles spent waiting for an acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CTR_W'(1);
    end
  end

  // Compared at the end of each bus cycle: a match ends the TIMEOUT-th cycle.
  assign expired = (count == CTR_W'(TIMEOUT - 1));

endmodule : wb_timeout_ctr

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-cycle initiator driven by a valid/ready command stream.
// Each accepted command runs one Wishbone cycle; the read data (or a timeout
// error) is returned on a valid/ready response channel. One command in flight.
// Ports:
//   wb_clk_i - clock
//   wb_rst_i - asynchronous active-high reset; drops cyc/stb immediately
//   bus      - wb_cmd_master_if.master: cmd_*, rsp_*, wbm_* signals
// Build option: define WB_CMD_MASTER_TIMEOUT_EN to abort a bus cycle after
// TIMEOUT cycles without ack (rsp_err=1). Without it the master waits for
// ack indefinitely and rsp_err is always 0.
module wb_cmd_master
  import wb_cmd_pkg::*;
#(
  parameter int unsigned ADR_W   = ADR_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  wb_cmd_master_if.master bus
);

  // Elaboration-time legality check on the timeout length.
  if (TIMEOUT == 0 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("wb_cmd_master: TIMEOUT must be in 1..65535");
  end

  state_t              state;
  logic                cmd_ready_q;
  logic                rsp_valid_q;
  rsp_t                rsp_q;
  logic                cyc_q;
  logic                we_q;
  logic [ADR_W-1:0]    adr_q;
  logic [WB_DAT_W-1:0] dat_q;
  logic [WB_SEL_W-1:0] sel_q;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  logic tmo_clear;
  logic tmo_en;
  logic tmo_expired;

  assign tmo_clear = (state == IDLE) && bus.cmd_valid;
  assign tmo_en    = (state == BUS) && !bus.wbm_ack_i;

  wb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clear   (tmo_clear),
    .enable  (tmo_en),
    .expired (tmo_expired)
  );
`endif

  // Command -> bus cycle -> response sequencer; every output is a register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            we_q        <= bus.cmd_we;
            adr_q       <= bus.cmd_adr;
            dat_q       <= bus.cmd_dat;
            sel_q       <= bus.cmd_sel;
            cyc_q       <= 1'b1;
            cmd_ready_q <= 1'b0;
            state       <= BUS;
          end
        end

        BUS: begin
          // Ack is checked first so an ack coinciding with expiry completes normally.
          if (bus.wbm_ack_i) begin
            rsp_q       <= '{dat: (we_q ? WB_DAT_W'(0) : bus.wbm_dat_i), err: 1'b0};
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end
`ifdef WB_CMD_MASTER_TIMEOUT_EN
          else if (tmo_expired) begin
            rsp_q       <= '{dat: WB_DAT_W'(0), err: 1'b1};
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end
`endif
        end

        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          cyc_q       <= 1'b0;
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_dat   = rsp_q.dat;
  assign bus.rsp_err   = rsp_q.err;
  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = cyc_q;
  assign bus.wbm_we_o  = we_q;
  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_dat_o = dat_q;
  assign bus.wbm_sel_o = sel_q;

endmodule : wb_cmd_master

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: directed steps followed by random
// commands, compared against a register-file model of the slave.
module tb_wb_cmd_master;
  import wb_cmd_pkg::*;

  localparam int unsigned ADR_W       = 4;
  localparam int          TMO         = 8;
  localparam int          HANG_CYCLES = 1000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;
  bit   hung;

  logic [31:0] ref_mem [16];
  logic [31:0] slv_mem [16];

  wb_cmd_master_if #(.ADR_W(ADR_W)) bus ();

  wb_cmd_master #(
    .ADR_W   (ADR_W),
    .TIMEOUT (TMO)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Bus cycles a command should occupy; -1 means no response will ever arrive.
  function automatic int exp_cycles(input int ws, input bit never);
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    if (never || ws + 1 > TMO) return TMO;
    return ws + 1;
`else
    if (never) return -1;
    return ws + 1;
`endif
  endfunction

  // One command: starts and ends at a falling edge with the DUT idle (unless hung).
  task automatic do_cmd(input bit we, input logic [3:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int ws, input bit never,
                        input int rsp_delay, input bit keep_valid, output bit hang);
    int          want;
    int          cyc_n;
    int          limit;
    bit          timed_out;
    logic [31:0] want_dat;
    hang      = 1'b0;
    want      = exp_cycles(ws, never);
    timed_out = (want >= 0) && (never || want != ws + 1);
    want_dat  = (timed_out || we) ? 32'h0 : ref_mem[adr];

    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_adr   = adr;
    bus.cmd_dat   = dat;
    bus.cmd_sel   = sel;
    bus.wbm_ack_i = 1'($urandom);
    bus.wbm_dat_i = $urandom;
    chk("idle_ready", {bus.cmd_ready, bus.rsp_valid, bus.wbm_cyc_o}, 3'b100);
    @(posedge clk);

    cyc_n = 0;
    limit = (want < 0) ? HANG_CYCLES : want + 4;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (!keep_valid) bus.cmd_valid = 1'b0;
      bus.wbm_ack_i = 1'b0;
      bus.wbm_dat_i = $urandom;
      if (bus.wbm_cyc_o !== 1'b1) break;
      cyc_n++;
      chk("bus_hold",
          {bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o, bus.wbm_sel_o,
           bus.cmd_ready, bus.rsp_valid},
          {1'b1, we, adr, dat, sel, 1'b0, 1'b0});
      if (!never && cyc_n == ws + 1) begin
        bus.wbm_ack_i = 1'b1;
        if (we) slv_mem[bus.wbm_adr_o] = merge(slv_mem[bus.wbm_adr_o], bus.wbm_dat_o, bus.wbm_sel_o);
        else    bus.wbm_dat_i = slv_mem[bus.wbm_adr_o];
      end
    end

    if (want < 0) begin
      chk("hang_cycles", 128'(cyc_n), 128'(HANG_CYCLES));
      bus.cmd_valid = 1'b0;
      hang = 1'b1;
      return;
    end

    chk("bus_cycles", 128'(cyc_n), 128'(want));
    chk("rsp_first", {bus.rsp_valid, bus.rsp_dat, bus.rsp_err, bus.wbm_stb_o},
        {1'b1, want_dat, timed_out, 1'b0});
    if (!timed_out && we) ref_mem[adr] = merge(ref_mem[adr], dat, sel);

    for (int d = 0; d < rsp_delay; d++) begin
      bus.rsp_ready = 1'b0;
      bus.wbm_ack_i = 1'($urandom);
      @(negedge clk);
      chk("rsp_stall",
          {bus.rsp_valid, bus.rsp_dat, bus.rsp_err, bus.cmd_ready, bus.wbm_cyc_o, bus.wbm_stb_o},
          {1'b1, want_dat, timed_out, 1'b0, 1'b0, 1'b0});
    end

    bus.rsp_ready = 1'b1;
    bus.wbm_ack_i = 1'b0;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_done", {bus.rsp_valid, bus.cmd_ready, bus.wbm_cyc_o}, 3'b010);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("reset_recover", {bus.cmd_ready, bus.rsp_valid, bus.wbm_cyc_o}, 3'b100);
  endtask

  initial begin
    logic [31:0] v;
    bit          we_r;
    bit          nv;
    n_checks = 0;
    n_err    = 0;
    rst      = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_adr   = '0;
    bus.cmd_dat   = '0;
    bus.cmd_sel   = '0;
    bus.rsp_ready = 1'b0;
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = '0;
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      ref_mem[i] = v;
      slv_mem[i] = v;
    end

    repeat (2) @(negedge clk);
    chk("reset_state",
        {bus.cmd_ready, bus.rsp_valid, bus.rsp_dat, bus.rsp_err, bus.wbm_cyc_o, bus.wbm_stb_o,
         bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_adr_o, bus.wbm_dat_o},
        {1'b1, 77'h0});
    rst = 1'b0;
    @(negedge clk);

    // zero-wait write
    do_cmd(1'b1, 4'h2, 32'h0000_1234, 4'hF, 0, 1'b0, 0, 1'b0, hung);

    // read with three wait states
    ref_mem[0] = 32'hDEAD_BEEF;
    slv_mem[0] = 32'hDEAD_BEEF;
    do_cmd(1'b0, 4'h0, 32'h0, 4'hF, 3, 1'b0, 1, 1'b0, hung);

    // slave never acks
    do_cmd(1'b0, 4'h7, 32'h0, 4'hF, 0, 1'b1, 1, 1'b0, hung);
    if (hung) pulse_reset();

    // ack on the last permitted bus cycle
    do_cmd(1'b0, 4'h2, 32'h0, 4'hF, TMO - 1, 1'b0, 0, 1'b0, hung);

    // response backpressure with command valid held high
    do_cmd(1'b1, 4'h9, 32'hA5C3_0F96, 4'b0101, 1, 1'b0, 5, 1'b1, hung);
    do_cmd(1'b1, 4'h9, 32'hA5C3_0F96, 4'b0101, 0, 1'b0, 0, 1'b0, hung);
    do_cmd(1'b0, 4'h9, 32'h0, 4'hF, 2, 1'b0, 0, 1'b0, hung);

    // reset two cycles into a bus cycle
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b0;
    bus.cmd_adr   = 4'h5;
    bus.cmd_dat   = 32'h0;
    bus.cmd_sel   = 4'hF;
    bus.wbm_ack_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("rst_bus_c1", bus.wbm_cyc_o, 1'b1);
    @(negedge clk);
    chk("rst_bus_c2", bus.wbm_cyc_o, 1'b1);
    #2 rst = 1'b1;
    #1 chk("rst_async_drop", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid, bus.cmd_ready}, 4'b0001);
    @(negedge clk);
    rst = 1'b0;
    bus.wbm_ack_i = 1'b1;
    chk("rst_release", {bus.cmd_ready, bus.rsp_valid}, 2'b10);
    @(negedge clk);
    chk("rst_late_ack", {bus.wbm_cyc_o, bus.rsp_valid, bus.cmd_ready}, 3'b001);
    bus.wbm_ack_i = 1'b0;

    // random commands
    for (int n = 0; n < 40; n++) begin
      we_r = 1'($urandom);
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      nv = ($urandom_range(0, 7) == 0);
`else
      nv = 1'b0;
`endif
      do_cmd(we_r, 4'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, TMO + 2)),
             nv, int'($urandom_range(0, 3)), 1'b0, hung);
      if (hung) pulse_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_wb_cmd_master

// File: doc/wb_cmd_master.md
# wb_cmd_master

Wishbone classic single-cycle initiator: the bus-master counterpart to the clock/seven-segment Wishbone register slave. It accepts read/write commands on a valid/ready interface, runs one Wishbone cycle per command against the slave's 4-bit register space, and returns read data or a timeout error on a valid/ready response interface. It is used for bring-up, for self-test, and for driving the clock peripheral from on-chip logic instead of the management SoC.

## Interface
- `ADR_W`, 4: address width, matching the slave's register decode.
- `TIMEOUT`, 255: number of cycles waited for `wbm_ack_i` before abort; legal range 1..65535.
- `wb_clk_i` in 1: the single clock.
- `wb_rst_i` in 1: reset; asynchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: the block can accept a command.
- `cmd_we` in 1: 1 = write, 0 = read.
- `cmd_adr` in ADR_W: register address.
- `cmd_dat` in 32: write data.
- `cmd_sel` in 4: byte selects.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_dat` out 32: read data (0 for writes and for errors).
- `rsp_err` out 1: the cycle timed out.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o` out 1 each: Wishbone master controls.
- `wbm_sel_o` out 4: byte selects.
- `wbm_adr_o` out ADR_W: address.
- `wbm_dat_o` out 32: write data.
- `wbm_dat_i` in 32: read data from the slave.
- `wbm_ack_i` in 1: slave acknowledge.

## Operation
- **FSM states:** IDLE, BUS, RESP.
- **Reset values:** state IDLE; all outputs 0 except `cmd_ready`=1.
- **IDLE:**
  - `cmd_ready`=1.
  - On `cmd_valid`, latch we/adr/dat/sel into the `wbm_*` output registers, clear the timeout counter, and go to BUS.
- **BUS:**
  - `wbm_cyc_o`=`wbm_stb_o`=1; all other `wbm_*` outputs are held stable.
  - On `wbm_ack_i`:
    - capture `wbm_dat_i` into `rsp_dat` on a read, or 0 on a write;
    - set `rsp_err`=0;
    - drop cyc/stb;
    - go to RESP.
  - Otherwise, increment the counter. When the counter equals TIMEOUT−1 without an ack:
    - drop cyc/stb;
    - set `rsp_dat`=0 and `rsp_err`=1;
    - go to RESP.
- **RESP:**
  - `rsp_valid`=1; `rsp_dat` and `rsp_err` are held.
  - On `rsp_ready`, go to IDLE.
- **Boundary cases:**
  - `wbm_ack_i` outside BUS is ignored.
  - Ack arriving in the same cycle as timeout expiry: the ack wins, giving a normal response.
  - `cmd_valid` while not in IDLE is ignored (`cmd_ready`=0); commands are never queued.
  - Reset asserted mid-cycle drops cyc/stb immediately and asynchronously; any pending response is discarded.

## Timing
- Command accepted at edge N: cyc/stb are high from just after N.
- Ack sampled high at edge M: cyc/stb are low and `rsp_valid`=1 from just after M.
  - Zero-wait slave (ack at N+1): command-to-response latency is 2 cycles.
- Timeout: cyc/stb stay high for exactly TIMEOUT cycles; `rsp_valid` rises right after the last of them.
- `cmd_ready` is back to 1 the cycle after the response handshake. Back-to-back throughput is therefore 1 command per 3 cycles against a zero-wait slave.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `WB_CMD_MASTER_TIMEOUT_EN`.
- Defined: timeout counter present, behaviour as above.
- Undefined:
  - the counter is removed;
  - BUS waits for an ack indefinitely;
  - `rsp_err` is tied 0;
  - the TIMEOUT parameter is ignored.

## Structure
- Shared package `wb_cmd_pkg`:
  - state enum (IDLE, BUS, RESP);
  - `WB_DAT_W`=32;
  - `WB_SEL_W`=4;
  - default `ADR_W`.
- One sub-module, `wb_timeout_ctr`:
  - inputs clear and enable;
  - output `expired`;
  - width $clog2(TIMEOUT);
  - instantiated only under `WB_CMD_MASTER_TIMEOUT_EN`.

## Test plan
- **Write:** we=1, adr=4'h2, dat=32'h0000_1234, sel=4'hF; slave acks after 0 wait states. Required:
  - one cyc/stb pulse of 1 cycle with the same adr/dat/sel on the bus;
  - rsp_valid 2 cycles after accept;
  - rsp_err=0, rsp_dat=0.
- **Read:** adr=4'h0; slave returns 32'hDEAD_BEEF with ack after 3 wait states. Required:
  - cyc/stb high for 4 cycles;
  - rsp_dat=32'hDEAD_BEEF, rsp_err=0.
- **Timeout:** TIMEOUT=8, slave never acks. Required:
  - cyc/stb high for exactly 8 cycles;
  - rsp_err=1, rsp_dat=0.
  - Same stimulus with the macro undefined: cyc stays high for 1000 cycles with no response.
- **Ack/expiry race:** TIMEOUT=8, ack arrives on the 8th BUS cycle. Required: normal response with data, rsp_err=0.
- **Backpressure:** rsp_ready held 0 for 5 cycles while cmd_valid is held 1. Required:
  - cmd_ready=0 and rsp fields stable throughout;
  - the second command is accepted only after the response handshake.
- **Reset mid-cycle:** assert wb_rst_i 2 cycles into BUS. Required:
  - cyc/stb drop to 0 without waiting for a clock edge;
  - after release, cmd_ready=1 and rsp_valid=0;
  - a late ack is ignored.
